sop_decimator: RTL and testbench

SOP_DECIMATOR -- requirements
Module: sop_decimator

---
 rtl/sop_decimator.sv | 118 +++++++++++
 tb/tb_sop_decimator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sop_decimator.sv
// sop_decimator
//   Averages blocks of N = 1, 2, 4 or 8 accepted sum-of-products samples and
//   emits one rounded result per block through a 2-entry output FIFO.
//   result = (sum of block + round) >> sel, round = 2^(sel-1) for sel > 0.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   sum_in holds a sample this cycle
//   in_ready   registered; 1 when the FIFO will have room next cycle
//   sum_in     unsigned sample, 2*width+1 bits
//   dec_sel    decimation select (N = 1 << dec_sel), latched at block start
//   out_valid  FIFO not empty
//   out_ready  downstream pop strobe
//   out_data   FIFO head (holds its last value when the FIFO is empty)
module sop_decimator #(
  parameter int width = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*width:0]   sum_in,
  input  logic [1:0]         dec_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*width:0]   out_data
);
  localparam int DW = 2*width + 1;
  localparam int AW = 2*width + 4;   // 8 * max sample + max round fits

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [3:0]      cnt;
  logic [1:0]      sel_lat;
  logic [DW-1:0]   tail;
  logic [1:0]      count;

  logic            xfer, done, push, pop;
  logic [1:0]      sel_eff;
  logic [AW-1:0]   acc_sum, rnd, rounded;
  logic [3:0]      cnt_inc;
  logic [DW-1:0]   result;
  logic [1:0]      count_nxt;

  always_comb begin
    xfer    = in_valid & in_ready;
    // The first sample of a block uses the live select; later ones the latched.
    sel_eff = (state == IDLE) ? dec_sel : sel_lat;
    acc_sum = ((state == IDLE) ? '0 : acc) + AW'(sum_in);
    cnt_inc = ((state == IDLE) ? 4'd0 : cnt) + 4'd1;
    done    = xfer && (cnt_inc == (4'd1 << sel_eff));
    rnd     = '0;
    case (sel_eff)
      2'd1:    rnd = AW'(1);
      2'd2:    rnd = AW'(2);
      2'd3:    rnd = AW'(4);
      default: rnd = '0;
    endcase
    rounded   = acc_sum + rnd;
    result    = DW'(rounded >> sel_eff);
    push      = done;
    pop       = out_valid & out_ready;
    count_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sel_lat   <= '0;
      tail      <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (xfer) begin
        if (done) begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          state <= ACCUM;
          acc   <= acc_sum;
          cnt   <= cnt_inc;
          if (state == IDLE) sel_lat <= dec_sel;
        end
      end

      // Two-entry FIFO: out_data is the head register, tail is the second slot.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) out_data <= result;
          else               tail     <= result;
        end
        2'b01: begin
          if (count == 2'd2) out_data <= tail;
        end
        2'b11: begin
          if (count == 2'd1) out_data <= result;
          else begin
            out_data <= tail;
            tail     <= result;
          end
        end
        default: ;
      endcase

      count     <= count_nxt;
      out_valid <= (count_nxt != 2'd0);
      in_ready  <= (count_nxt < 2'd2);
    end
  end
endmodule

// File: tb/tb_sop_decimator.sv
module tb_sop_decimator;
  localparam int W = 4;

  logic           clk = 0;
  logic           reset = 1;
  logic           in_valid = 0;
  logic           in_ready;
  logic [2*W:0]   sum_in = '0;
  logic [1:0]     dec_sel = '0;
  logic           out_valid;
  logic           out_ready = 0;
  logic [2*W:0]   out_data;

  int checks = 0;
  int failures = 0;

  sop_decimator #(.width(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .dec_sel(dec_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: samples of the open block, list of pending results,
  // and a log of every result the consumer took.
  int  blk[$];
  int  bn, bsel;
  int  mq[$];
  int  log_q[$];
  int  m_last = 0;
  bit  m_ready = 0;
  bit  m_xfer = 0;
  bit  started = 0;

  always @(posedge clk) begin
    bit pop, push;
    int res, s;
    m_xfer = 0;
    push = 0;
    res = 0;
    if (reset) begin
      blk.delete();
      mq.delete();
      m_ready = 0;
      m_last = 0;
      started = 1;
    end else begin
      pop = (mq.size() > 0) && out_ready;
      m_xfer = in_valid && m_ready;
      if (m_xfer) begin
        if (blk.size() == 0) begin
          bsel = int'(dec_sel);
          bn = 1 << bsel;
        end
        blk.push_back(int'(sum_in));
        if (blk.size() == bn) begin
          s = 0;
          foreach (blk[i]) s += blk[i];
          res = (s + bn / 2) / bn;
          push = 1;
          blk.delete();
        end
      end
      if (pop) begin
        m_last = mq.pop_front();
        log_q.push_back(m_last);
      end
      if (push) mq.push_back(res);
      m_ready = (mq.size() < 2);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(m_ready));
      chk("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
      chk("out_data", int'(out_data), (mq.size() > 0) ? mq[0] : m_last);
    end
  end

  task automatic send(input int v, input logic [1:0] ds);
    int n;
    in_valid = 1;
    sum_in = (2*W+1)'(v);
    dec_sel = ds;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_xfer && n < 50);
    if (!m_xfer) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_log(input string nm, input int e[$]);
    chk({nm, "_count"}, log_q.size(), e.size());
    foreach (e[i]) chk(nm, (i < log_q.size()) ? log_q[i] : -1, e[i]);
  endtask

  initial begin
    int e[$];
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // N = 1 passthrough with one-cycle latency
    out_ready = 1;
    log_q.delete();
    send(300, 2'd0);
    chk("pass_valid", int'(out_valid), 1);
    chk("pass_data", int'(out_data), 300);
    @(negedge clk);
    chk("pass_valid_after", int'(out_valid), 0);
    e = {300};
    check_log("pass", e);

    // Rounding
    log_q.delete();
    send(10, 2'd2); send(20, 2'd2); send(30, 2'd2); send(41, 2'd2);
    send(3, 2'd1); send(4, 2'd1);
    drain();
    e = {25, 4};
    check_log("round", e);

    // Max value, no accumulator wrap
    log_q.delete();
    repeat (8) send(511, 2'd3);
    drain();
    e = {511};
    check_log("max", e);

    // Backpressure
    log_q.delete();
    out_ready = 0;
    send(5, 2'd0);
    send(6, 2'd0);
    in_valid = 1;
    sum_in = 7;
    repeat (3) @(negedge clk);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_out_data", int'(out_data), 5);
    chk("bp_log_empty", log_q.size(), 0);
    out_ready = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_xfer && n < 50);
    if (!m_xfer) chk("bp_timeout", 0, 1);
    in_valid = 0;
    drain();
    e = {5, 6, 7};
    check_log("bp", e);

    // Reset mid-block
    log_q.delete();
    send(100, 2'd2); send(100, 2'd2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    send(1, 2'd2); send(2, 2'd2); send(3, 2'd2); send(4, 2'd2);
    drain();
    e = {3};
    check_log("rst_mid", e);

    // dec_sel change mid-block is ignored until the next block
    log_q.delete();
    send(8, 2'd2);
    send(8, 2'd0); send(8, 2'd0); send(8, 2'd0);
    send(9, 2'd0);
    drain();
    e = {8, 9};
    check_log("sel_change", e);

    // Randomized traffic checked cycle-by-cycle against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sum_in    = (2*W+1)'($urandom_range(0, 511));
      dec_sel   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    reset = 0;
    in_valid = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
